// File: rtl/sal_bank_sched.sv
// -----------------------------------------------------------------------------
// sal_bank_sched
//
// Inter-bank command scheduler between the per-bank DDR2 controllers and the
// command issue stage. Each cycle it collects the ACT/RD/WR/PRE/REF requests
// from all banks, applies the shared timing windows (tRRD, tFAW, tCCD, tWTR,
// tRTW), grants at most one bank/command and registers the chosen command
// toward the issue stage. Per-bank timing (tRCD, tRAS, tRP, ...) is owned by
// the bank controllers.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_t_*_m1                shared timing values (cycles minus one)
//   i_*_req [NUM_BANKS]     per-bank request strobes (act/rd/wr/pre/ref)
//   i_ra/ca/id/len/seq      per-bank address and metadata for the request
//   o_*_gnt [NUM_BANKS]     per-bank grants, combinational, one-hot overall
//   i_cmd_ready             issue stage accepts a command this cycle
//   o_cmd_valid             registered command valid (cycle after grant)
//   o_cmd_type              1=ACT 2=RD 3=WR 4=PRE 5=REF, 0 when idle
//   o_cmd_ba/ra/ca          bank index, row and column of the command
//   o_cmd_id/len/seq        transaction metadata of the command
// -----------------------------------------------------------------------------
module sal_bank_sched #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BA_W      = 3,
  parameter int unsigned RA_W      = 14,
  parameter int unsigned CA_W      = 10,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned SEQ_W     = 8,
  parameter int unsigned TW        = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  // shared timing parameters
  input  logic [TW-1:0]        i_t_rrd_m1,
  input  logic [TW-1:0]        i_t_faw_m1,
  input  logic [TW-1:0]        i_t_ccd_m1,
  input  logic [TW-1:0]        i_t_wtr_m1,
  input  logic [TW-1:0]        i_t_rtw_m1,
  // per-bank requests
  input  logic [NUM_BANKS-1:0] i_act_req,
  input  logic [NUM_BANKS-1:0] i_rd_req,
  input  logic [NUM_BANKS-1:0] i_wr_req,
  input  logic [NUM_BANKS-1:0] i_pre_req,
  input  logic [NUM_BANKS-1:0] i_ref_req,
  input  logic [RA_W-1:0]      i_ra  [NUM_BANKS],
  input  logic [CA_W-1:0]      i_ca  [NUM_BANKS],
  input  logic [ID_W-1:0]      i_id  [NUM_BANKS],
  input  logic [LEN_W-1:0]     i_len [NUM_BANKS],
  input  logic [SEQ_W-1:0]     i_seq [NUM_BANKS],
  // per-bank grants
  output logic [NUM_BANKS-1:0] o_act_gnt,
  output logic [NUM_BANKS-1:0] o_rd_gnt,
  output logic [NUM_BANKS-1:0] o_wr_gnt,
  output logic [NUM_BANKS-1:0] o_pre_gnt,
  output logic [NUM_BANKS-1:0] o_ref_gnt,
  // issue stage
  input  logic                 i_cmd_ready,
  output logic                 o_cmd_valid,
  output logic [2:0]           o_cmd_type,
  output logic [BA_W-1:0]      o_cmd_ba,
  output logic [RA_W-1:0]      o_cmd_ra,
  output logic [CA_W-1:0]      o_cmd_ca,
  output logic [ID_W-1:0]      o_cmd_id,
  output logic [LEN_W-1:0]     o_cmd_len,
  output logic [SEQ_W-1:0]     o_cmd_seq
);

  localparam int unsigned BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_REF  = 3'd5;

  // Timing window counters; zero means the window is closed.
  logic [TW-1:0] r_rrd;
  logic [TW-1:0] r_ccd;
  logic [TW-1:0] r_wtr;
  logic [TW-1:0] r_rtw;
  logic [TW-1:0] r_faw [4];
  logic [BW-1:0] r_rr_ptr;

  // Registered command
  logic             r_cmd_valid;
  logic [2:0]       r_cmd_type;
  logic [BA_W-1:0]  r_cmd_ba;
  logic [RA_W-1:0]  r_cmd_ra;
  logic [CA_W-1:0]  r_cmd_ca;
  logic [ID_W-1:0]  r_cmd_id;
  logic [LEN_W-1:0] r_cmd_len;
  logic [SEQ_W-1:0] r_cmd_seq;

  logic [NUM_BANKS-1:0] w_sel_ref, w_sel_rd, w_sel_wr, w_sel_pre, w_sel_act;
  logic [NUM_BANKS-1:0] w_cand_ref, w_cand_col, w_cand_pre, w_cand_act;
  logic [NUM_BANKS-1:0] w_cls_vec;
  logic [NUM_BANKS-1:0] w_onehot;
  logic                 w_rd_ok, w_wr_ok, w_act_ok;
  logic                 w_faw_any;
  logic [1:0]           w_faw_slot;
  logic                 w_found;
  logic [BW-1:0]        w_gnt_idx;
  logic                 w_grant;
  logic [2:0]           w_gnt_type;
  logic                 w_act_g, w_rd_g, w_wr_g;

  function automatic logic [TW-1:0] dec(input logic [TW-1:0] v);
    return (v == '0) ? v : v - TW'(1);
  endfunction

  // A bank presenting several request types keeps only its highest one.
  always_comb begin
    w_sel_ref = i_ref_req;
    w_sel_rd  = ~i_ref_req & i_rd_req;
    w_sel_wr  = ~i_ref_req & ~i_rd_req & i_wr_req;
    w_sel_pre = ~i_ref_req & ~i_rd_req & ~i_wr_req & i_pre_req;
    w_sel_act = ~i_ref_req & ~i_rd_req & ~i_wr_req & ~i_pre_req & i_act_req;
  end

  // Lowest-index free tFAW slot; none free means four ACTs are in flight.
  always_comb begin
    w_faw_any  = 1'b0;
    w_faw_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_faw[i] == '0) begin
        w_faw_any  = 1'b1;
        w_faw_slot = 2'(i);
      end
    end
  end

  always_comb begin
    w_rd_ok  = (r_ccd == '0) && (r_wtr == '0);
    w_wr_ok  = (r_ccd == '0) && (r_rtw == '0);
    w_act_ok = (r_rrd == '0) && w_faw_any;

    w_cand_ref = w_sel_ref;
    w_cand_col = (w_sel_rd & {NUM_BANKS{w_rd_ok}}) | (w_sel_wr & {NUM_BANKS{w_wr_ok}});
    w_cand_pre = w_sel_pre;
    w_cand_act = w_sel_act & {NUM_BANKS{w_act_ok}};

    // Class choice only looks at eligible candidates, so a blocked
    // higher class falls through to a lower one.
    if (|w_cand_ref)      w_cls_vec = w_cand_ref;
    else if (|w_cand_col) w_cls_vec = w_cand_col;
    else if (|w_cand_pre) w_cls_vec = w_cand_pre;
    else                  w_cls_vec = w_cand_act;
  end

  // Round-robin pick within the winning class, starting at r_rr_ptr.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      logic [BW-1:0] j;
      j = BW'((32'(r_rr_ptr) + i) % NUM_BANKS);
      if (!w_found && w_cls_vec[j]) begin
        w_found   = 1'b1;
        w_gnt_idx = j;
      end
    end
  end

  assign w_grant = w_found & i_cmd_ready & i_rst_n;

  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      w_onehot[b] = w_grant && (w_gnt_idx == BW'(b));
    end
  end

  // Each bank has at most one select bit set, so masking the one-hot bank
  // vector with the selects yields a grant that is one-hot across types.
  assign o_ref_gnt = w_onehot & w_sel_ref;
  assign o_rd_gnt  = w_onehot & w_sel_rd;
  assign o_wr_gnt  = w_onehot & w_sel_wr;
  assign o_pre_gnt = w_onehot & w_sel_pre;
  assign o_act_gnt = w_onehot & w_sel_act;

  always_comb begin
    w_gnt_type = CMD_IDLE;
    if (w_grant) begin
      if (w_sel_ref[w_gnt_idx])      w_gnt_type = CMD_REF;
      else if (w_sel_rd[w_gnt_idx])  w_gnt_type = CMD_RD;
      else if (w_sel_wr[w_gnt_idx])  w_gnt_type = CMD_WR;
      else if (w_sel_pre[w_gnt_idx]) w_gnt_type = CMD_PRE;
      else                           w_gnt_type = CMD_ACT;
    end
  end

  assign w_act_g = (w_gnt_type == CMD_ACT);
  assign w_rd_g  = (w_gnt_type == CMD_RD);
  assign w_wr_g  = (w_gnt_type == CMD_WR);

  // A load of v keeps the counter non-zero for the next v cycles; a load
  // on a running counter simply overwrites it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rrd    <= '0;
      r_ccd    <= '0;
      r_wtr    <= '0;
      r_rtw    <= '0;
      for (int i = 0; i < 4; i++) r_faw[i] <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_rrd <= w_act_g ? i_t_rrd_m1 : dec(r_rrd);
      r_ccd <= (w_rd_g || w_wr_g) ? i_t_ccd_m1 : dec(r_ccd);
      r_wtr <= w_wr_g ? i_t_wtr_m1 : dec(r_wtr);
      r_rtw <= w_rd_g ? i_t_rtw_m1 : dec(r_rtw);
      for (int i = 0; i < 4; i++) begin
        r_faw[i] <= (w_act_g && (w_faw_slot == 2'(i))) ? i_t_faw_m1 : dec(r_faw[i]);
      end
      if (w_grant) begin
        r_rr_ptr <= BW'((32'(w_gnt_idx) + 32'd1) % NUM_BANKS);
      end
    end
  end

  // Command register toward the issue stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= CMD_IDLE;
      r_cmd_ba    <= '0;
      r_cmd_ra    <= '0;
      r_cmd_ca    <= '0;
      r_cmd_id    <= '0;
      r_cmd_len   <= '0;
      r_cmd_seq   <= '0;
    end else if (w_grant) begin
      r_cmd_valid <= 1'b1;
      r_cmd_type  <= w_gnt_type;
      r_cmd_ba    <= BA_W'(w_gnt_idx);
      r_cmd_ra    <= i_ra[w_gnt_idx];
      r_cmd_ca    <= i_ca[w_gnt_idx];
      r_cmd_id    <= i_id[w_gnt_idx];
      r_cmd_len   <= i_len[w_gnt_idx];
      r_cmd_seq   <= i_seq[w_gnt_idx];
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= CMD_IDLE;
    end
  end

  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_type  = r_cmd_type;
  assign o_cmd_ba    = r_cmd_ba;
  assign o_cmd_ra    = r_cmd_ra;
  assign o_cmd_ca    = r_cmd_ca;
  assign o_cmd_id    = r_cmd_id;
  assign o_cmd_len   = r_cmd_len;
  assign o_cmd_seq   = r_cmd_seq;

endmodule

// File: doc/sal_bank_sched.md
# sal_bank_sched

Command scheduler between the per-bank controllers and the DDR2 command issue stage. Each cycle it collects the ACT/RD/WR/PRE/REF requests from all bank controllers and enforces the inter-bank timing constraints (tRRD, tFAW, tCCD, tWTR, tRTW). It grants at most one bank and one command, and registers the chosen command toward the issue stage. The per-bank constraints (tRCD, tRAS, tRP, tRC, tRFC, tRTP, tWR) stay with the bank controllers.

## Interface
- NUM_BANKS, 4: number of bank controllers, power of 2, ≤8.
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- timing_if  TIMING_IF.MON  -  uses t_rrd_m1, t_faw_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1
- bk_reqs  in  bk_req_t[NUM_BANKS]  per-bank request bundle (act/rd/wr/pre/ref_req, ba, ra, ca, id, len, seq_num)
- bk_gnts  out  bk_gnt_t[NUM_BANKS]  per-bank grant bundle (act/rd/wr/pre/ref_gnt), combinational
- cmd_ready  in  1  issue stage can take a command this cycle
- cmd_valid  out  1  registered command valid
- cmd_type  out  3  1=ACT 2=RD 3=WR 4=PRE 5=REF, 0 when idle
- cmd_ba / cmd_ra / cmd_ca  out  DRAM_BA/RA/CA widths  address of issued command
- cmd_id / cmd_len / cmd_seq  out  axi_id_t / axi_len_t / seq_num_t  metadata (RD/WR)

## Operation
- A bank's request is eligible when its class constraint holds:
  - REF and PRE: always eligible.
  - ACT: rrd_zero and at least one FAW slot is zero.
  - RD: ccd_zero and wtr_zero.
  - WR: ccd_zero and rtw_zero.
- A bank asserts at most one request type per cycle. If it asserts more than one, the priority order below picks among them.
- Class priority: REF > RD/WR (column) > PRE > ACT.
  - Within the winning class, round-robin starting at rr_ptr, wrapping modulo NUM_BANKS.
  - RD and WR share the column class.
- The grant is issued only when cmd_ready=1. It is one-hot across all banks and all types. With cmd_ready=0, every bk_gnts bit is 0.
- On a grant, rr_ptr ← (granted bank + 1) mod NUM_BANKS. Without a grant, rr_ptr is unchanged.
- Counter loads at the grant cycle:
  - ACT loads rrd ← t_rrd_m1, and loads the lowest-index zero FAW slot (4 slots) ← t_faw_m1.
  - RD loads ccd ← t_ccd_m1 and rtw ← t_rtw_m1.
  - WR loads ccd ← t_ccd_m1 and wtr ← t_wtr_m1.
- Counter semantics match SAL_TIMING_CNTR: a load of v at cycle N makes the counter non-zero in N+1..N+v, and zero again from N+v+1.
  - The same-class next grant is earliest at N+v+1, i.e. v+1 cycles spacing.
  - A load on an already non-zero counter overwrites it.
- Command register: on a grant at N, the cmd_* fields capture the granted bank's type, ba, ra, ca, id, len and seq_num.
  - ba is the bank index.
  - For PRE and REF, ra and ca are passed through as sent (0).
  - cmd_valid=1 for exactly cycle N+1, and drops to 0 the next cycle unless there is another grant.

## Timing
- Grant latency: 0 cycles, combinational from bk_reqs, counters, rr_ptr and cmd_ready.
- Command output latency: 1 cycle after the grant.
- Reset values:
  - cmd_valid=0, cmd_type=0, and all cmd_* fields = 0.
  - All counters 0, rr_ptr=0.
  - bk_gnts=0 while rst_n=0.
- Reset mid-operation clears all timing windows immediately. The first grant after release is unconstrained.
- The tFAW window is saturated when all 4 slots are non-zero: ACT is blocked, and lower classes still proceed.
- A blocked higher class does not block a lower class. Example: an ineligible RD due to tWTR lets a PRE or ACT win that cycle.
- Simultaneous REF requests are served one per cycle in round-robin order.

## Test plan
- Round-robin: NUM_BANKS=4, banks 0–3 all hold pre_req, cmd_ready=1 → grants 0,1,2,3 on consecutive cycles; cmd_type=4 on cycles 1–4.
- tRRD: t_rrd_m1=2, banks 0 and 1 request ACT at cycle 0 → bank0 ACT at 0, bank1 ACT at 3; cmd_valid at 1 and 4.
- tFAW: t_rrd_m1=0, t_faw_m1=9, banks 0–3 ACT then bank0 ACT again (after a PRE) → first four ACTs at 0–3, fifth ACT not before cycle 10.
- Write-to-read: t_wtr_m1=5, t_ccd_m1=1, WR bank0 at cycle 0 with RD bank1 pending → RD granted at 6. A PRE from bank2 pending meanwhile is granted at 1.
- Priority and backpressure: bank2 ref_req, bank1 rd_req, bank0 act_req, cmd_ready=0 for 3 cycles → no grants. Then REF (bank2), RD (bank1), ACT (bank0) on consecutive cycles.
- Reset: assert rst_n=0 while ccd is at 3 and cmd_valid=1 → cmd_valid=0 asynchronously. After release, RD is granted on the first cycle.
